freq_window_detect: RTL and testbench

- Producer side of the PLL lock-detect interface: generates the freqUp/freqDn pulse trains and the ldDivideEnable window that the lock detector consumes.
- Counts synchronized rising edges of the divided feedback clock over a programmable window of `clock` cycles and compares the count against a target.
- Emits a number of freqUp or freqDn pulses proportional to the error, saturated.
- Sits between the feedback divider output and the lock detector / loop control.

---
 rtl/freq_window_detect_pkg.sv | 16 +
 rtl/freq_window_detect_sync_edge_detect.sv | 26 ++
 rtl/freq_window_detect.sv | 134 +++++++++++++
 tb/tb_freq_window_detect.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_window_detect_pkg.sv
// Shared definitions for the feedback-frequency window detector: FSM state
// encoding and the default pulse saturation limit.
package freq_window_detect_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COUNT   = 3'd1,
    COMPARE = 3'd2,
    REPORT  = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam int DEF_PULSE_BITS = 4;
  localparam int MAX_PULSES     = (1 << DEF_PULSE_BITS) - 1;

endpackage

// File: rtl/freq_window_detect_sync_edge_detect.sv
// Two-flop synchronizer plus delay flop; emits a one-cycle pulse for each
// rising edge of an input that is asynchronous to clock.
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic s1, s2, s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= level;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_window_detect.sv
// Counts synchronized feedback-clock edges over a programmable window and
// reports the error against a target as saturated freqUp/freqDn pulse trains.
module freq_window_detect
  import freq_window_detect_pkg::*;
#(
  parameter int WINDOW_BITS   = 8,
  parameter int FB_COUNT_BITS = 10,
  parameter int PULSE_BITS    = DEF_PULSE_BITS
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [WINDOW_BITS-1:0]          windowLength,
  input  logic [FB_COUNT_BITS-1:0]        targetCount,
  input  logic                            fbClock,
  output logic                            freqUp,
  output logic                            freqDn,
  output logic                            ldDivideEnable,
  output logic [FB_COUNT_BITS-1:0]        fbCount,
  output logic                            countValid,
  output logic signed [FB_COUNT_BITS:0]   freqError
);

  localparam logic [FB_COUNT_BITS:0] PULSE_MAX_W = (FB_COUNT_BITS+1)'((1 << PULSE_BITS) - 1);

  state_t                        state;
  logic [WINDOW_BITS-1:0]        win_cnt;
  logic [WINDOW_BITS-1:0]        win_start;
  logic [FB_COUNT_BITS-1:0]      edge_cnt;
  logic [FB_COUNT_BITS-1:0]      edge_next;
  logic [PULSE_BITS-1:0]         pulse_cnt;
  logic [PULSE_BITS-1:0]         pulse_sat;
  logic signed [FB_COUNT_BITS:0] err;
  logic [FB_COUNT_BITS:0]        err_mag;
  logic                          fb_rise;

  sync_edge_detect u_sync (
    .clock (clock),
    .reset (reset),
    .level (fbClock),
    .rise  (fb_rise)
  );

  always_comb begin
    win_start = (windowLength == '0) ? WINDOW_BITS'(1) : windowLength;
    edge_next = edge_cnt;
    if (fb_rise && (edge_cnt != '1))
      edge_next = edge_cnt + FB_COUNT_BITS'(1);
    err       = $signed({1'b0, targetCount}) - $signed({1'b0, edge_cnt});
    err_mag   = err[FB_COUNT_BITS] ? $unsigned(-err) : $unsigned(err);
    pulse_sat = (err_mag > PULSE_MAX_W) ? PULSE_MAX_W[PULSE_BITS-1:0] : err_mag[PULSE_BITS-1:0];
  end

  // Outputs are registered from the next state, so freqUp/freqDn line up with
  // REPORT cycles and countValid appears with the newly latched fbCount.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      win_cnt        <= '0;
      edge_cnt       <= '0;
      pulse_cnt      <= '0;
      fbCount        <= '0;
      freqError      <= '0;
      countValid     <= 1'b0;
      freqUp         <= 1'b0;
      freqDn         <= 1'b0;
      ldDivideEnable <= 1'b0;
    end else begin
      countValid <= 1'b0;
      freqUp     <= 1'b0;
      freqDn     <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state          <= COUNT;
            win_cnt        <= win_start;
            edge_cnt       <= '0;
            ldDivideEnable <= 1'b1;
          end
        end
        COUNT: begin
          if (!enable) begin
            state          <= IDLE;
            ldDivideEnable <= 1'b0;
          end else begin
            edge_cnt <= edge_next;
            win_cnt  <= win_cnt - WINDOW_BITS'(1);
            if (win_cnt == WINDOW_BITS'(1))
              state <= COMPARE;
          end
        end
        COMPARE: begin
          fbCount    <= edge_cnt;
          freqError  <= err;
          countValid <= 1'b1;
          if (err == '0) begin
            state          <= GAP;
            ldDivideEnable <= 1'b0;
          end else begin
            state     <= REPORT;
            pulse_cnt <= pulse_sat;
            freqUp    <= ~err[FB_COUNT_BITS];
            freqDn    <= err[FB_COUNT_BITS];
          end
        end
        REPORT: begin
          pulse_cnt <= pulse_cnt - PULSE_BITS'(1);
          if (pulse_cnt == PULSE_BITS'(1)) begin
            state          <= GAP;
            ldDivideEnable <= 1'b0;
          end else begin
            freqUp <= freqUp;
            freqDn <= freqDn;
          end
        end
        GAP: begin
          if (enable) begin
            state          <= COUNT;
            win_cnt        <= win_start;
            edge_cnt       <= '0;
            ldDivideEnable <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state          <= IDLE;
          ldDivideEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_freq_window_detect.sv
// Bench for freq_window_detect: window-level reference model checked every
// cycle, a directed vector table and hand-written enable/reset sequences.
module tb_freq_window_detect;
  import freq_window_detect_pkg::*;

  localparam int MAXC = 60000;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              fbClock = 1'b0;
  logic [7:0]        windowLength = '0;
  logic [9:0]        targetCount = '0;
  logic              freqUp, freqDn, ldDivideEnable, countValid;
  logic [9:0]        fbCount;
  logic signed [10:0] freqError;

  freq_window_detect dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .windowLength   (windowLength),
    .targetCount    (targetCount),
    .fbClock        (fbClock),
    .freqUp         (freqUp),
    .freqDn         (freqDn),
    .ldDivideEnable (ldDivideEnable),
    .fbCount        (fbCount),
    .countValid     (countValid),
    .freqError      (freqError)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // fbClock waveform and its value at each posedge, as the synchronizer sees it
  int fb_period = 0;
  int fb_ph = 0;
  bit samp [0:MAXC-1];

  // Window-level model: start cycle, length, pulse count and result
  bit in_win = 1'b0;
  int s = 0, w_len = 1, p_len = 0, cnt_m = 0, err_m = 0;
  int exp_fb = 0, exp_err = 0;

  bit o_cv, o_up, o_dn, o_ld;
  int o_fb, o_err;

  typedef struct {
    int win; int tgt; int per; int e_fb; int e_err; int e_up; int e_dn;
  } vec_t;
  vec_t vecs [6];

  task automatic checkVal(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput;
    int o;
    bit e_ld, e_cv, e_up, e_dn;
    o = cyc - s;
    e_ld = in_win && (o < w_len + 1 + p_len);
    e_cv = in_win && (o == w_len + 1);
    e_up = in_win && (err_m > 0) && (o >= w_len + 1) && (o < w_len + 1 + p_len);
    e_dn = in_win && (err_m < 0) && (o >= w_len + 1) && (o < w_len + 1 + p_len);
    if (e_cv) begin
      exp_fb  = cnt_m;
      exp_err = err_m;
    end
    checkVal("ldDivideEnable", int'(ldDivideEnable), int'(e_ld));
    checkVal("countValid", int'(countValid), int'(e_cv));
    checkVal("freqUp", int'(freqUp), int'(e_up));
    checkVal("freqDn", int'(freqDn), int'(e_dn));
    checkVal("fbCount", int'(fbCount), exp_fb);
    checkVal("freqError", int'(freqError), exp_err);
  endtask

  task automatic sampleCycle;
    @(negedge clock);
    checkOutput();
    o_cv = countValid; o_up = freqUp; o_dn = freqDn; o_ld = ldDivideEnable;
    o_fb = int'(fbCount); o_err = int'(freqError);
  endtask

  task automatic startWindow(input int at);
    in_win = 1'b1;
    s      = at;
    w_len  = (windowLength == 8'd0) ? 1 : int'(windowLength);
    p_len  = 0;
  endtask

  // Edges whose detect pulse lands in a COUNT cycle are the ones counted
  task automatic finishWindow;
    int cnt, mag;
    cnt = 0;
    for (int n = s - 1; n <= s + w_len - 2; n++)
      if (n >= 1 && n < MAXC && samp[n] && !samp[n-1]) cnt++;
    if (cnt > 1023) cnt = 1023;
    cnt_m = cnt;
    err_m = int'(targetCount) - cnt;
    mag   = (err_m < 0) ? -err_m : err_m;
    p_len = (mag > MAX_PULSES) ? MAX_PULSES : mag;
  endtask

  task automatic applyStimulus(input bit rst, input bit en);
    int o;
    reset  = rst;
    enable = en;
    if (fb_period > 0) begin
      fbClock = (fb_ph < fb_period / 2);
      fb_ph   = (fb_ph + 1) % fb_period;
    end else begin
      fbClock = 1'b0;
    end
    if (cyc + 1 < MAXC) samp[cyc+1] = rst ? fbClock : 1'b0;
    o = cyc - s;
    if (!rst) begin
      in_win = 1'b0; exp_fb = 0; exp_err = 0;
    end else if (in_win) begin
      if (o < w_len && !en)              in_win = 1'b0;
      else if (o == w_len)               finishWindow();
      else if (o == w_len + 1 + p_len) begin
        if (en) startWindow(cyc + 1);
        else    in_win = 1'b0;
      end
    end else if (en) begin
      startWindow(cyc + 1);
    end
  endtask

  task automatic resetDut;
    for (int i = 0; i < 3; i++) begin sampleCycle(); applyStimulus(1'b0, 1'b0); end
    for (int i = 0; i < 3; i++) begin sampleCycle(); applyStimulus(1'b1, 1'b0); end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    bit got_cv, done;
    int ups, dns, cap_fb, cap_err;
    fb_period = v.per; fb_ph = 0;
    windowLength = 8'(v.win); targetCount = 10'(v.tgt);
    resetDut();
    got_cv = 0; done = 0; ups = 0; dns = 0; cap_fb = -1; cap_err = -9999;
    for (int k = 0; k < 3000 && !done; k++) begin
      sampleCycle();
      if (o_cv && !got_cv) begin got_cv = 1; cap_fb = o_fb; cap_err = o_err; end
      ups += int'(o_up);
      dns += int'(o_dn);
      done = got_cv && !o_ld;
      applyStimulus(1'b1, !done);
    end
    checkVal($sformatf("vec%0d window completed", idx), int'(done), 1);
    checkVal($sformatf("vec%0d fbCount", idx), cap_fb, v.e_fb);
    checkVal($sformatf("vec%0d freqError", idx), cap_err, v.e_err);
    checkVal($sformatf("vec%0d freqUp pulses", idx), ups, v.e_up);
    checkVal($sformatf("vec%0d freqDn pulses", idx), dns, v.e_dn);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int ups, ld_low, cvs, pulses, k;
    bit en, got;
    vecs[0] = '{16, 4, 4, 4, 0, 0, 0};
    vecs[1] = '{16, 8, 8, 2, 6, 6, 0};
    vecs[2] = '{100, 2, 4, 25, -23, 0, 15};
    vecs[3] = '{12, 1, 3, 4, -3, 0, 3};
    vecs[4] = '{30, 20, 6, 5, 15, 15, 0};
    vecs[5] = '{64, 40, 4, 16, 24, 15, 0};

    #1 reset = 1'b0;
    resetDut();

    for (int i = 0; i < 6; i++) runVector(vecs[i], i);

    // windowLength=0: three-cycle windows, ldDivideEnable low only in GAP
    fb_period = 0; windowLength = 8'd0; targetCount = 10'd0;
    resetDut();
    sampleCycle(); applyStimulus(1'b1, 1'b1);
    ld_low = 0; cvs = 0;
    for (int i = 0; i < 30; i++) begin
      sampleCycle();
      ld_low += int'(!o_ld);
      cvs    += int'(o_cv);
      applyStimulus(1'b1, 1'b1);
    end
    checkVal("win0 ld low cycles", ld_low, 10);
    checkVal("win0 countValid strobes", cvs, 10);

    // enable dropped mid-COUNT: window abandoned
    fb_period = 4; windowLength = 8'd20; targetCount = 10'd9;
    resetDut();
    for (int i = 0; i < 6; i++) begin sampleCycle(); applyStimulus(1'b1, 1'b1); end
    sampleCycle(); applyStimulus(1'b1, 1'b0);
    cvs = 0; pulses = 0; ld_low = 0;
    for (int i = 0; i < 30; i++) begin
      sampleCycle();
      cvs    += int'(o_cv);
      pulses += int'(o_up) + int'(o_dn);
      ld_low += int'(!o_ld);
      applyStimulus(1'b1, 1'b0);
    end
    checkVal("abort countValid", cvs, 0);
    checkVal("abort pulses", pulses, 0);
    checkVal("abort ld low cycles", ld_low, 30);

    // enable dropped mid-REPORT: all six pulses still delivered
    fb_period = 8; windowLength = 8'd16; targetCount = 10'd8;
    resetDut();
    en = 1; ups = 0;
    for (int i = 0; i < 200; i++) begin
      sampleCycle();
      ups += int'(o_up);
      if (ups >= 2) en = 0;
      applyStimulus(1'b1, en);
    end
    checkVal("report drop freqUp pulses", ups, 6);
    checkVal("report drop ld after", int'(o_ld), 0);

    // reset during REPORT after three pulses, then a fresh window
    resetDut();
    ups = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      sampleCycle();
      ups += int'(o_up);
      if (ups == 3) begin got = 1; applyStimulus(1'b0, 1'b1); end
      else applyStimulus(1'b1, 1'b1);
    end
    checkVal("reset reached 3 pulses", int'(got), 1);
    #1;
    checkVal("reset freqUp", int'(freqUp), 0);
    checkVal("reset freqDn", int'(freqDn), 0);
    checkVal("reset ldDivideEnable", int'(ldDivideEnable), 0);
    checkVal("reset countValid", int'(countValid), 0);
    checkVal("reset fbCount", int'(fbCount), 0);
    checkVal("reset freqError", int'(freqError), 0);
    sampleCycle(); applyStimulus(1'b0, 1'b1);
    sampleCycle(); applyStimulus(1'b1, 1'b1);
    got = 0; k = 0;
    for (int i = 1; i <= 100 && !got; i++) begin
      sampleCycle();
      if (o_cv) begin got = 1; k = i; end
      applyStimulus(1'b1, 1'b1);
    end
    checkVal("fresh window countValid latency", k, 18);

    // Randomized run against the window model
    resetDut();
    for (int i = 0; i < 6000; i++) begin
      sampleCycle();
      if ($urandom_range(0, 3) == 0) windowLength = 8'($urandom_range(0, 120));
      if ($urandom_range(0, 3) == 0) targetCount = 10'($urandom_range(0, 60));
      if ($urandom_range(0, 199) == 0) begin fb_period = $urandom_range(3, 9); fb_ph = 0; end
      applyStimulus($urandom_range(0, 799) != 0, $urandom_range(0, 149) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
